addsub_pipe: RTL
================

// Module: addsub_pipe
// PURPOSE
//  Pipelined N-bit add/subtract unit, successor to the combinational subtractor in SimpleALU.
//  Splits the carry chain into STAGES registered chunks, so wide operands close timing.
//  Adds a valid/ready handshake with backpressure and a full flag set (carry/borrow, overflow, zero, neg).
//  Sits between the ALU operand mux and the result writeback register.
// PARAMETERS
//  N       8  operand/result width in bits; must be divisible by STAGES
//  STAGES  2  pipeline depth = number of carry-chain chunks; each chunk is W = N/STAGES bits
// PORTS
//  clk_i        in   1  clock, rising edge
//  rst_i        in   1  asynchronous reset, active-high
//  in_valid_i   in   1  operands and op are valid this cycle
//  in_ready_o   out  1  unit accepts operands this cycle
//  op_i         in   1  alu_pkg::addsub_op_e: OP_ADD=0, OP_SUB=1
//  a_i          in   N  first operand
//  b_i          in   N  second operand
//  out_valid_o  out  1  result and flags are valid
//  out_ready_i  in   1  downstream accepts the result
//  res_o        out  N  a+b or a-b (wrapped, or clamped under ADDSUB_SAT_EN)
//  flags_o      out  4  alu_pkg::addsub_flags_t {carry, ovf, zero, neg}
// BEHAVIOUR
//  - Transfer on in_valid_i & in_ready_o (input) and on out_valid_o & out_ready_i (output).
//  - Arithmetic: SUB computes a + ~b + 1 (carry-in 1); ADD computes a + b (carry-in 0).
//  - Stage k (0..STAGES-1) adds chunk k [k*W +: W] using the carry registered from stage k-1.
//    Upper operand chunks and lower result chunks travel in skew registers alongside.
//  - Latency: exactly STAGES cycles from input accept to out_valid_o when there is no stall.
//    Throughput: 1 op/cycle.
//  - Stall: stall = out_valid_o & ~out_ready_i; in_ready_o = ~stall.
//    While stalled, every stage register holds; no op is lost, duplicated or reordered.
//  - Bubbles: each stage carries its own valid bit; invalid stages still advance when not stalled.
//  - Flags (computed in the final stage):
//    carry = carry-out for ADD; borrow = ~carry-out for SUB (1 when a < b unsigned).
//    ovf   = signed overflow = carry into MSB ^ carry out of MSB.
//    zero  = (res_o == 0), taken after saturation.
//    neg   = true sign of the signed result = raw MSB ^ ovf.
//  - Reset: all stage valid bits, out_valid_o, res_o and flags_o are 0; in_ready_o is 1.
//    Reset mid-operation discards all in-flight ops. The first op after reset release
//    emerges after STAGES cycles.
//  - With STAGES=1 the unit is a single registered stage (latency 1).
//  - Simultaneous output handshake and input accept in the same cycle is legal: the pipe advances.
// CONFIGURATION
//  - ADDSUB_SAT_EN defined: on ovf=1, res_o clamps to signed max when neg=0 and to signed min
//    when neg=1 (e.g. 0x7F / 0x80 for N=8). Flags still report ovf=1.
//  - ADDSUB_SAT_EN undefined: res_o wraps modulo 2^N; the clamp mux is not generated.
// STRUCTURE
//  - alu_pkg holds: addsub_op_e enum, addsub_flags_t packed struct {carry, ovf, zero, neg},
//    and localparam helpers for the W derivation.
//  - Sub-module addsub_slice #(W): combinational W-bit ripple full-adder chain.
//    Ports: a, b (pre-inverted for SUB), cin -> sum, cout, and c_msb_in (carry into MSB,
//    needed for ovf). One instance per stage; addsub_pipe owns all registers and handshake.
// TESTING (N=8, STAGES=2 unless noted)
//  - SUB 5,3 -> res 0x02, carry(borrow)=0, ovf=0, zero=0, neg=0, out_valid_o 2 cycles after accept.
//  - SUB 3,5 -> res 0xFE, borrow=1, neg=1; SUB 7,7 -> res 0x00, zero=1, borrow=0.
//  - ADD 0x7F,0x01 -> ovf=1, neg=0; res 0x80 (wrap) or 0x7F with ADDSUB_SAT_EN.
//    SUB 0x80,0x01 -> ovf=1, neg=1; res 0x7F (wrap) or 0x80 with ADDSUB_SAT_EN.
//  - Back-to-back 4 ops, out_ready_i low for 3 cycles mid-stream -> in_ready_o low exactly
//    while stalled; all 4 results appear in order with correct values.
//  - Assert rst_i with 2 ops in flight -> out_valid_o 0 asynchronously; no stale result after
//    release; the next op (ADD 1,1 -> 0x02) appears after 2 cycles.
//  - Random 10k ops at N=32, STAGES=4 with random valid/ready -> matches reference model
//    $signed/unsigned arithmetic and all flags.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: shared types and width helpers for the pipelined add/subtract unit.
package alu_pkg;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } addsub_op_e;

  // Result flags, MSB first: {carry, ovf, zero, neg}
  typedef struct packed {
    logic carry;
    logic ovf;
    logic zero;
    logic neg;
  } addsub_flags_t;

  localparam int ADDSUB_N_DEFAULT      = 8;
  localparam int ADDSUB_STAGES_DEFAULT = 2;

  // Width of one carry-chain chunk; N must be a multiple of STAGES.
  function automatic int chunk_width(input int n, input int stages);
    return n / stages;
  endfunction

  // Operand bits still waiting to be added when stage k starts.
  function automatic int rem_width(input int n, input int w, input int k);
    return n - k * w;
  endfunction

endpackage

// File: rtl/addsub_slice.sv
// addsub_slice: combinational W-bit ripple-carry adder for one pipeline chunk.
// For subtraction the caller pre-inverts b and drives cin high.
module addsub_slice #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         c_msb_in
);

  logic carry;

  // Ripple the carry through the chunk, tapping the carry that enters the top bit.
  always_comb begin
    carry    = cin;
    sum      = '0;
    c_msb_in = cin;
    for (int i = 0; i < W; i++) begin
      if (i == W - 1) begin
        c_msb_in = carry;
      end
      sum[i] = a[i] ^ b[i] ^ carry;
      carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
    end
    cout = carry;
  end

endmodule

// File: rtl/addsub_pipe.sv
// addsub_pipe: pipelined N-bit add/subtract with valid/ready handshake and flags.
// The carry chain is cut into STAGES chunks of W = N/STAGES bits; stage k adds
// chunk k with the carry registered by stage k-1 while the remaining operand
// chunks and the finished low sum chunks ride along in skew registers.
// Build option: ADDSUB_SAT_EN clamps the result to signed max/min on overflow.
module addsub_pipe
  import alu_pkg::*;
#(
  parameter int N      = ADDSUB_N_DEFAULT,
  parameter int STAGES = ADDSUB_STAGES_DEFAULT
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic         op_i,
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [N-1:0] res_o,
  output logic [3:0]   flags_o
);

  localparam int W = chunk_width(N, STAGES);

  logic          stall;
  logic          is_sub;
  logic [N-1:0]  b_eff;
  logic          out_valid_reg;
  logic [N-1:0]  res_reg;
  addsub_flags_t flags_reg;

  // A full output register that downstream refuses freezes the whole pipe.
  assign stall  = out_valid_reg & ~out_ready_i;
  assign is_sub = (addsub_op_e'(op_i) == OP_SUB);
  assign b_eff  = b_i ^ {N{is_sub}};

  assign in_ready_o  = ~stall;
  assign out_valid_o = out_valid_reg;
  assign res_o       = res_reg;
  assign flags_o     = flags_reg;

  genvar gi;
  for (gi = 0; gi < STAGES; gi++) begin : stage_g
    localparam int REM = rem_width(N, W, gi);

    logic               v_in;
    logic               sub_in;
    logic               cin;
    logic [REM-1:0]     a_src;
    logic [REM-1:0]     b_src;
    logic [(gi+1)*W-1:0] sum_acc;
    logic [W-1:0]       s;
    logic               cout;
    logic               c_msb;

    addsub_slice #(.W(W)) slice_u (
      .a        (a_src[W-1:0]),
      .b        (b_src[W-1:0]),
      .cin      (cin),
      .sum      (s),
      .cout     (cout),
      .c_msb_in (c_msb)
    );

    if (gi == 0) begin : src_g
      assign v_in    = in_valid_i;
      assign sub_in  = is_sub;
      assign cin     = is_sub;
      assign a_src   = a_i;
      assign b_src   = b_eff;
      assign sum_acc = s;
    end else begin : src_g
      assign v_in    = stage_g[gi-1].mid_g.valid_reg;
      assign sub_in  = stage_g[gi-1].mid_g.sub_reg;
      assign cin     = stage_g[gi-1].mid_g.carry_reg;
      assign a_src   = stage_g[gi-1].mid_g.a_up_reg;
      assign b_src   = stage_g[gi-1].mid_g.b_up_reg;
      assign sum_acc = {s, stage_g[gi-1].mid_g.sum_reg};
    end

    if (gi < STAGES - 1) begin : mid_g
      logic                valid_reg;
      logic                sub_reg;
      logic                carry_reg;
      logic [(gi+1)*W-1:0] sum_reg;
      logic [REM-W-1:0]    a_up_reg;
      logic [REM-W-1:0]    b_up_reg;
      logic                c_msb_unused;

      // Only the last chunk's MSB carry matters for overflow.
      assign c_msb_unused = c_msb;

      // Hand this chunk's carry, partial sum and untouched operand chunks to the next stage.
      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          valid_reg <= 1'b0;
          sub_reg   <= 1'b0;
          carry_reg <= 1'b0;
          sum_reg   <= '0;
          a_up_reg  <= '0;
          b_up_reg  <= '0;
        end else if (!stall) begin
          valid_reg <= v_in;
          if (v_in) begin
            sub_reg   <= sub_in;
            carry_reg <= cout;
            sum_reg   <= sum_acc;
            a_up_reg  <= a_src[REM-1:W];
            b_up_reg  <= b_src[REM-1:W];
          end
        end
      end
    end else begin : fin_g
      logic          ovf;
      logic          neg;
      logic [N-1:0]  res_next;
      addsub_flags_t flags_next;

      assign ovf = cout ^ c_msb;
      assign neg = sum_acc[N-1] ^ ovf;

      // Form the final result (optionally clamped) and its flags.
      always_comb begin
        res_next         = sum_acc;
        flags_next       = '0;
        flags_next.carry = sub_in ? ~cout : cout;
        flags_next.ovf   = ovf;
        flags_next.neg   = neg;
`ifdef ADDSUB_SAT_EN
        if (ovf) begin
          res_next = neg ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
        end
`endif
        flags_next.zero = (res_next == '0);
      end

      // Output register: loads a new result whenever the pipe advances.
      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          out_valid_reg <= 1'b0;
          res_reg       <= '0;
          flags_reg     <= '0;
        end else if (!stall) begin
          out_valid_reg <= v_in;
          if (v_in) begin
            res_reg   <= res_next;
            flags_reg <= flags_next;
          end
        end
      end
    end
  end

endmodule
